// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the bus-based CPU datapath: widths, ALU op
// encoding with its priority order, and bus-source encoding.
package cpu_datapath_pkg;

    localparam int WORD_W    = 32;
    localparam int DWORD_W   = 64;
    localparam int NUM_GPR   = 16;
    localparam int NUM_OPS   = 14;
    localparam int C_FIELD_W = 19;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [DWORD_W-1:0] dword_t;

    // Strobe bit i (0 = IncPC ... 13 = DIV) maps to enum value i+1, so the
    // declaration order below is also the priority order.
    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_INC_PC,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SHR,
        OP_SHRA,
        OP_SHL,
        OP_ROR,
        OP_ROL,
        OP_NEG,
        OP_NOT,
        OP_MUL,
        OP_DIV
    } alu_op_e;

    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_GPR,
        SRC_HI,
        SRC_LO,
        SRC_ZHIGH,
        SRC_ZLOW,
        SRC_PC,
        SRC_MDR,
        SRC_INPORT,
        SRC_C
    } bus_src_e;

    // Lowest-numbered asserted strobe wins; no strobe gives OP_NONE.
    function automatic alu_op_e pick_op(input logic [NUM_OPS-1:0] strobes);
        alu_op_e op;
        op = OP_NONE;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (strobes[i]) op = alu_op_e'(4'(i + 1));
        end
        return op;
    endfunction

    // Immediate constant C: the low instruction field, sign-extended.
    function automatic word_t sext_c(input logic [C_FIELD_W-1:0] field);
        return {{(WORD_W - C_FIELD_W){field[C_FIELD_W-1]}}, field};
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result for Z.
module alu
    import cpu_datapath_pkg::*;
(
    input  word_t   a,
    input  word_t   b,
    input  alu_op_e op,
    output dword_t  result
);

    logic [4:0]         sh;
    dword_t             rot_src;
    word_t              ror_word;
    word_t              rol_word;
    logic signed [63:0] product;
    logic               a_neg;
    logic               b_neg;
    word_t              a_mag;
    word_t              b_mag;
    word_t              divisor;
    word_t              q_mag;
    word_t              r_mag;
    word_t              quotient;
    word_t              remainder;

    assign sh      = b[4:0];
    assign rot_src = {a, a};
    assign ror_word = word_t'(rot_src >> sh);
    // Rotating left by s equals rotating right by 32-s; s = 0 shifts by 32.
    assign rol_word = word_t'(rot_src >> (6'd32 - {1'b0, sh}));
    assign product  = $signed({{WORD_W{a[WORD_W-1]}}, a})
                    * $signed({{WORD_W{b[WORD_W-1]}}, b});

    // Signed division is done on magnitudes so no operand pair (including
    // the most-negative dividend over -1) can trap or overflow.
    assign a_neg     = a[WORD_W-1];
    assign b_neg     = b[WORD_W-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign divisor   = (b == '0) ? word_t'(1) : b_mag;
    assign q_mag     = a_mag / divisor;
    assign r_mag     = a_mag % divisor;
    assign quotient  = (b == '0) ? '1 : ((a_neg ^ b_neg) ? -q_mag : q_mag);
    assign remainder = (b == '0) ? a : (a_neg ? -r_mag : r_mag);

    // Select the result of the single winning operation.
    always_comb begin
        // NOTE: default first so every path assigns result and no latch forms.
        result = '0;
        unique case (op)
            OP_INC_PC: result = {32'b0, b + 32'd1};
            OP_ADD:    result = {32'b0, a + b};
            OP_SUB:    result = {32'b0, a - b};
            OP_AND:    result = {32'b0, a & b};
            OP_OR:     result = {32'b0, a | b};
            OP_SHR:    result = {32'b0, a >> sh};
            OP_SHRA:   result = {32'b0, word_t'($signed(a) >>> sh)};
            OP_SHL:    result = {32'b0, a << sh};
            OP_ROR:    result = {32'b0, ror_word};
            OP_ROL:    result = {32'b0, rol_word};
            OP_NEG:    result = {32'b0, -b};
            OP_NOT:    result = {32'b0, ~b};
            OP_MUL:    result = dword_t'(product);
            OP_DIV:    result = {remainder, quotient};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath_reg32.sv
// 32-bit register with load enable and asynchronous active-low clear.
module reg32
    import cpu_datapath_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  word_t d,
    output word_t q
);

    // Hold unless enabled; clear wins asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every register samples the bus
        // value from before the edge, even when it also drives that bus.
        if (!rst_n) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, special registers, Z and the ALU
// all exchange data over one combinational 32-bit bus.
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL,
    input  logic        NEG, NOT, MUL, DIV,
    input  logic        Read,
    input  logic [31:0] Mdatain,
    output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
    output logic [31:0] HI, LO, PC_out, IR, MAR, Y,
    output logic [63:0] Z,
    output logic [31:0] BusMuxOut_signal
);

    word_t                gpr_q [NUM_GPR];
    logic [NUM_GPR-1:0]   gpr_in;
    logic [NUM_GPR-1:0]   gpr_out;
    logic [NUM_OPS-1:0]   op_strobes;
    word_t                hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
    dword_t               z_q;
    word_t                bus;
    word_t                c_value;
    dword_t               alu_result;
    alu_op_e              alu_op;
    bus_src_e             bus_src;
    logic [3:0]           gpr_sel;

    assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign gpr_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign op_strobes = {DIV, MUL, NOT, NEG, ROL, ROR, SHL, SHRA, SHR,
                         OR, AND, SUB, ADD, IncPC};

    assign c_value = sext_c(ir_q[C_FIELD_W-1:0]);
    assign alu_op  = pick_op(op_strobes);

    // NOTE: every register, the whole register file included, sits on the
    // asynchronous clear because all outputs must read zero during reset.
    for (genvar i = 0; i < NUM_GPR; i++) begin : g_gpr
        reg32 u_gpr (.clk(clock), .rst_n(clear), .en(gpr_in[i]), .d(bus), .q(gpr_q[i]));
    end

    reg32 u_hi  (.clk(clock), .rst_n(clear), .en(HIin),  .d(bus), .q(hi_q));
    reg32 u_lo  (.clk(clock), .rst_n(clear), .en(LOin),  .d(bus), .q(lo_q));
    reg32 u_pc  (.clk(clock), .rst_n(clear), .en(PCin),  .d(bus), .q(pc_q));
    reg32 u_ir  (.clk(clock), .rst_n(clear), .en(IRin),  .d(bus), .q(ir_q));
    reg32 u_mar (.clk(clock), .rst_n(clear), .en(MARin), .d(bus), .q(mar_q));
    reg32 u_y   (.clk(clock), .rst_n(clear), .en(Yin),   .d(bus), .q(y_q));
    reg32 u_mdr (.clk(clock), .rst_n(clear), .en(MDRin),
                 .d(Read ? Mdatain : bus), .q(mdr_q));

    alu u_alu (.a(y_q), .b(bus), .op(alu_op), .result(alu_result));

    // Bus source arbitration: lowest priority is written first and later
    // (higher priority) assignments override it.
    always_comb begin
        bus_src = SRC_NONE;
        gpr_sel = '0;
        if (Cout)      bus_src = SRC_C;
        if (InPortout) bus_src = SRC_INPORT;
        if (MDRout)    bus_src = SRC_MDR;
        if (PCout)     bus_src = SRC_PC;
        if (Zlowout)   bus_src = SRC_ZLOW;
        if (Zhighout)  bus_src = SRC_ZHIGH;
        if (LOout)     bus_src = SRC_LO;
        if (HIout)     bus_src = SRC_HI;
        for (int i = NUM_GPR - 1; i >= 0; i--) begin
            if (gpr_out[i]) begin
                bus_src = SRC_GPR;
                gpr_sel = 4'(i);
            end
        end
    end

    // Bus data mux driven by the winning source.
    always_comb begin
        bus = '0;
        unique case (bus_src)
            SRC_GPR:    bus = gpr_q[gpr_sel];
            SRC_HI:     bus = hi_q;
            SRC_LO:     bus = lo_q;
            SRC_ZHIGH:  bus = z_q[DWORD_W-1:WORD_W];
            SRC_ZLOW:   bus = z_q[WORD_W-1:0];
            SRC_PC:     bus = pc_q;
            SRC_MDR:    bus = mdr_q;
            SRC_INPORT: bus = '0;
            SRC_C:      bus = c_value;
            default:    bus = '0;
        endcase
    end

    // Z captures the full ALU result; with no op strobed the ALU yields 0.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)   z_q <= '0;
        else if (Zin) z_q <= alu_result;
    end

    assign R0  = gpr_q[0];
    assign R1  = gpr_q[1];
    assign R2  = gpr_q[2];
    assign R3  = gpr_q[3];
    assign R4  = gpr_q[4];
    assign R5  = gpr_q[5];
    assign R6  = gpr_q[6];
    assign R7  = gpr_q[7];
    assign R8  = gpr_q[8];
    assign R9  = gpr_q[9];
    assign R10 = gpr_q[10];
    assign R11 = gpr_q[11];
    assign R12 = gpr_q[12];
    assign R13 = gpr_q[13];
    assign R14 = gpr_q[14];
    assign R15 = gpr_q[15];
    assign HI  = hi_q;
    assign LO  = lo_q;
    assign PC_out = pc_q;
    assign IR  = ir_q;
    assign MAR = mar_q;
    assign Y   = y_q;
    assign Z   = z_q;
    assign BusMuxOut_signal = bus;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed sequences plus random
// strobes, all compared against an arithmetic model of the datapath.
module tb_cpu_datapath;

    localparam int E_HI = 0, E_LO = 1, E_PC = 2, E_IR = 3, E_Y = 4, E_Z = 5, E_MAR = 6, E_MDR = 7;
    localparam int S_HI = 0, S_LO = 1, S_ZH = 2, S_ZL = 3, S_PC = 4, S_MDR = 5, S_IN = 6, S_C = 7;
    localparam int O_INC = 0, O_ADD = 1, O_SUB = 2, O_AND = 3, O_OR = 4, O_SHR = 5, O_SHRA = 6;
    localparam int O_SHL = 7, O_ROR = 8, O_ROL = 9, O_NEG = 10, O_NOT = 11, O_MUL = 12, O_DIV = 13;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] rin, rout;
    logic [7:0]  sin, sout;
    logic [13:0] ops;
    logic        rd;
    logic [31:0] mdatain;

    logic [31:0] gpr_q [16];
    logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, y_q, bus_q;
    logic [63:0] z_q;

    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
    logic [63:0] m_z;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cpu_datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(sin[E_HI]), .LOin(sin[E_LO]), .PCin(sin[E_PC]), .IRin(sin[E_IR]),
        .Yin(sin[E_Y]), .Zin(sin[E_Z]), .MARin(sin[E_MAR]), .MDRin(sin[E_MDR]),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(sout[S_HI]), .LOout(sout[S_LO]), .Zhighout(sout[S_ZH]), .Zlowout(sout[S_ZL]),
        .PCout(sout[S_PC]), .MDRout(sout[S_MDR]), .InPortout(sout[S_IN]), .Cout(sout[S_C]),
        .IncPC(ops[O_INC]), .ADD(ops[O_ADD]), .SUB(ops[O_SUB]), .AND(ops[O_AND]),
        .OR(ops[O_OR]), .SHR(ops[O_SHR]), .SHRA(ops[O_SHRA]), .SHL(ops[O_SHL]),
        .ROR(ops[O_ROR]), .ROL(ops[O_ROL]), .NEG(ops[O_NEG]), .NOT(ops[O_NOT]),
        .MUL(ops[O_MUL]), .DIV(ops[O_DIV]),
        .Read(rd), .Mdatain(mdatain),
        .R0(gpr_q[0]), .R1(gpr_q[1]), .R2(gpr_q[2]), .R3(gpr_q[3]),
        .R4(gpr_q[4]), .R5(gpr_q[5]), .R6(gpr_q[6]), .R7(gpr_q[7]),
        .R8(gpr_q[8]), .R9(gpr_q[9]), .R10(gpr_q[10]), .R11(gpr_q[11]),
        .R12(gpr_q[12]), .R13(gpr_q[13]), .R14(gpr_q[14]), .R15(gpr_q[15]),
        .HI(hi_q), .LO(lo_q), .PC_out(pc_q), .IR(ir_q), .MAR(mar_q), .Y(y_q),
        .Z(z_q), .BusMuxOut_signal(bus_q)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus value by the documented source priority.
    function automatic logic [31:0] model_bus();
        int g;
        logic signed [31:0] t;
        g = -1;
        for (int i = 0; i < 16; i++) if (rout[i] && g < 0) g = i;
        if (g >= 0)        return m_gpr[g];
        if (sout[S_HI])    return m_hi;
        if (sout[S_LO])    return m_lo;
        if (sout[S_ZH])    return m_z[63:32];
        if (sout[S_ZL])    return m_z[31:0];
        if (sout[S_PC])    return m_pc;
        if (sout[S_MDR])   return m_mdr;
        if (sout[S_IN])    return 32'h0;
        if (sout[S_C]) begin
            t = m_ir << 13;
            return t >>> 13;
        end
        return 32'h0;
    endfunction

    // ALU result from plain integer arithmetic on the winning strobe.
    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b);
        int sa, sb, s, op;
        longint q, r;
        sa = a;
        sb = b;
        s  = int'(b & 32'd31);
        op = -1;
        for (int i = 0; i < 14; i++) if (ops[i] && op < 0) op = i;
        case (op)
            O_INC:  return {32'h0, b + 32'd1};
            O_ADD:  return {32'h0, a + b};
            O_SUB:  return {32'h0, a - b};
            O_AND:  return {32'h0, a & b};
            O_OR:   return {32'h0, a | b};
            O_SHR:  return {32'h0, a >> s};
            O_SHRA: return {32'h0, 32'(sa >>> s)};
            O_SHL:  return {32'h0, a << s};
            O_ROR:  return {32'h0, (s == 0) ? a : ((a >> s) | (a << (32 - s)))};
            O_ROL:  return {32'h0, (s == 0) ? a : ((a << s) | (a >> (32 - s)))};
            O_NEG:  return {32'h0, 32'h0 - b};
            O_NOT:  return {32'h0, ~b};
            O_MUL:  return longint'(sa) * longint'(sb);
            O_DIV: begin
                if (sb == 0) return {a, 32'hFFFF_FFFF};
                q = longint'(sa) / longint'(sb);
                r = longint'(sa) % longint'(sb);
                return {r[31:0], q[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0;
        m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;
    endtask

    task automatic idle();
        rin = '0; rout = '0; sin = '0; sout = '0; ops = '0; rd = 1'b0; mdatain = '0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) check($sformatf("R%0d", i), {32'h0, gpr_q[i]}, {32'h0, m_gpr[i]});
        check("HI", {32'h0, hi_q}, {32'h0, m_hi});
        check("LO", {32'h0, lo_q}, {32'h0, m_lo});
        check("PC", {32'h0, pc_q}, {32'h0, m_pc});
        check("IR", {32'h0, ir_q}, {32'h0, m_ir});
        check("MAR", {32'h0, mar_q}, {32'h0, m_mar});
        check("Y", {32'h0, y_q}, {32'h0, m_y});
        check("Z", z_q, m_z);
    endtask

    // Entered just after a rising edge with strobes set: checks the bus,
    // clocks once, updates the model and checks every register.
    task automatic step();
        logic [31:0] nb;
        logic [63:0] nz;
        #2;
        nb = model_bus();
        nz = model_alu(m_y, nb);
        check("bus", {32'h0, bus_q}, {32'h0, nb});
        @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) if (rin[i]) m_gpr[i] = nb;
        if (sin[E_HI])  m_hi  = nb;
        if (sin[E_LO])  m_lo  = nb;
        if (sin[E_PC])  m_pc  = nb;
        if (sin[E_IR])  m_ir  = nb;
        if (sin[E_Y])   m_y   = nb;
        if (sin[E_MAR]) m_mar = nb;
        if (sin[E_MDR]) m_mdr = rd ? mdatain : nb;
        if (sin[E_Z])   m_z   = nz;
        check_regs();
        idle();
    endtask

    task automatic peek_bus(input string tag, input logic [31:0] exp);
        #2;
        check(tag, {32'h0, bus_q}, {32'h0, exp});
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        rd = 1'b1; sin[E_MDR] = 1'b1; mdatain = v;
        step();
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] v);
        load_mdr(v);
        sout[S_MDR] = 1'b1; rin[idx] = 1'b1;
        step();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        sout[S_MDR] = 1'b1; sin[E_Y] = 1'b1;
        step();
    endtask

    task automatic alu_gpr(input int src, input int op);
        rout[src] = 1'b1; ops[op] = 1'b1; sin[E_Z] = 1'b1;
        step();
    endtask

    task automatic z_to_lo_hi();
        sout[S_ZL] = 1'b1; sin[E_LO] = 1'b1;
        step();
        sout[S_ZH] = 1'b1; sin[E_HI] = 1'b1;
        step();
    endtask

    task automatic random_steps(input int n);
        int k, idx;
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 16; i++) rin[i] = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 8; i++)  sin[i] = ($urandom_range(0, 5) == 0);
            sin[E_Z] = ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                idx = $urandom_range(0, 23);
                if (idx < 16) rout[idx] = 1'b1;
                else          sout[idx - 16] = 1'b1;
            end
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) ops[$urandom_range(0, 13)] = 1'b1;
            rd = ($urandom_range(0, 1) == 1);
            mdatain = $urandom;
            step();
        end
    endtask

    int          sh_ops [4];
    logic [63:0] sh_exp [4];

    initial begin
        idle();
        model_reset();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_regs();
        check("reset_bus", {32'h0, bus_q}, 64'h0);
        clear = 1'b1;

        load_gpr(1, 32'd5);
        load_gpr(3, 32'h14);
        check("load_r1", {32'h0, gpr_q[1]}, 64'd5);
        check("load_r3", {32'h0, gpr_q[3]}, 64'h14);

        // 20 / 5
        rout[3] = 1'b1; sin[E_Y] = 1'b1; step();
        alu_gpr(1, O_DIV); z_to_lo_hi();
        check("div_lo", {32'h0, lo_q}, 64'd4);
        check("div_hi", {32'h0, hi_q}, 64'd0);

        // -7 / 2
        load_gpr(3, 32'hFFFF_FFF9);
        load_gpr(1, 32'd2);
        rout[3] = 1'b1; sin[E_Y] = 1'b1; step();
        alu_gpr(1, O_DIV); z_to_lo_hi();
        check("divneg_lo", {32'h0, lo_q}, 64'hFFFF_FFFD);
        check("divneg_hi", {32'h0, hi_q}, 64'hFFFF_FFFF);

        // -7 / 0
        load_gpr(1, 32'd0);
        alu_gpr(1, O_DIV); z_to_lo_hi();
        check("div0_lo", {32'h0, lo_q}, 64'hFFFF_FFFF);
        check("div0_hi", {32'h0, hi_q}, 64'hFFFF_FFF9);

        load_y(32'h8000_0000); load_gpr(2, 32'd2); alu_gpr(2, O_MUL);
        check("mul_neg", z_q, 64'hFFFF_FFFF_0000_0000);
        load_y(32'd7); load_gpr(2, 32'd6); alu_gpr(2, O_MUL);
        check("mul_42", z_q, 64'd42);

        // Instruction fetch from PC = 0
        sout[S_PC] = 1'b1; sin[E_MAR] = 1'b1; ops[O_INC] = 1'b1; sin[E_Z] = 1'b1;
        step();
        check("fetch_mar", {32'h0, mar_q}, 64'h0);
        check("fetch_z", z_q, 64'd1);
        sout[S_ZL] = 1'b1; sin[E_PC] = 1'b1; rd = 1'b1; sin[E_MDR] = 1'b1; mdatain = 32'h112B_0000;
        step();
        check("fetch_pc", {32'h0, pc_q}, 64'd1);
        sout[S_MDR] = 1'b1; sin[E_IR] = 1'b1;
        step();
        check("fetch_ir", {32'h0, ir_q}, 64'h112B_0000);

        load_y(32'h0F0F); load_gpr(4, 32'h00FF);
        alu_gpr(4, O_AND); check("and", z_q, 64'h000F);
        alu_gpr(4, O_OR);  check("or", z_q, 64'h0FFF);

        sh_ops = '{O_SHR, O_SHRA, O_ROR, O_ROL};
        sh_exp = '{64'h4000_0000, 64'hC000_0000, 64'hC000_0000, 64'h0000_0003};
        load_y(32'h8000_0001); load_gpr(4, 32'd1);
        for (int i = 0; i < 4; i++) begin
            alu_gpr(4, sh_ops[i]);
            check($sformatf("shift%0d", i), z_q, sh_exp[i]);
        end

        peek_bus("bus_none", 32'h0);
        load_gpr(2, 32'hAAAA); load_gpr(5, 32'h5555);
        rout[2] = 1'b1; rout[5] = 1'b1;
        peek_bus("bus_prio", 32'hAAAA);
        load_mdr(32'h0004_0000); sout[S_MDR] = 1'b1; sin[E_IR] = 1'b1; step();
        sout[S_C] = 1'b1;
        peek_bus("bus_c", 32'hFFFC_0000);
        alu_gpr(4, O_NEG);
        check("neg1", z_q, 64'h0000_0000_FFFF_FFFF);

        random_steps(250);

        // Clear mid-sequence: zeroing is immediate and loads are ignored.
        load_y(32'h1234_5678);
        rout[1] = 1'b1; ops[O_DIV] = 1'b1; sin[E_Z] = 1'b1; sin[E_Y] = 1'b1; rin[7] = 1'b1;
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("clr_bus", {32'h0, bus_q}, 64'h0);
        @(posedge clock);
        #1;
        check_regs();
        clear = 1'b1;
        idle();

        random_steps(150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
